// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffered {pc,instr} entry, word size.
// No logic; imported by fetch_fifo and instr_fetch_unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_MISS,
        S_FULL
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: registered write, combinational head read (1-cycle push-to-head latency).
// Push is dropped when full without a same-edge pop; flush is synchronous and overrides push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    // Gate the head so stale or never-written storage is never visible downstream.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential word PCs into the I-cache, miss stalls, redirects, {pc,instr} buffer to decode.
// Cache word to instr_valid in 1 cycle; fetch pauses (oe_n=1) while the buffer is full and not popped.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = 32'h0040_0000,
    parameter int          FIFO_DEPTH    = 4
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic [31:0]                   cache_addr,
    output logic                          cache_ce_n,
    output logic                          cache_oe_n,
    input  logic [31:0]                   cache_data,
    input  logic                          cache_hold,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr_data,
    output logic [31:0]                   instr_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam logic [31:0] START_PC = word_align(START_ADDRESS);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          pending_q, pending_d;
    logic [31:0]   target_q, target_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic          room;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [31:0]   redirect_aligned;
    logic [31:0]   pc_next_seq;

    assign redirect_aligned = word_align(redirect_pc);
    assign pc_next_seq      = pc_q + 32'(WORD_BYTES);
    assign fifo_pop         = instr_ready && !fifo_empty;
    assign room             = !fifo_full || fifo_pop;
    assign push_entry       = '{pc: pc_q, instr: cache_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_BOOT;
            pc_q      <= START_PC;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            pending_q <= 1'b0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            pending_q <= pending_d;
            target_q  <= target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                if (redirect_valid)  state_d = S_FETCH;
                else if (cache_hold) state_d = S_MISS;
                else if (!room)      state_d = S_FULL;
            end
            S_MISS: begin
                if (!cache_hold) begin
                    if (redirect_valid || pending_q || room) state_d = S_FETCH;
                    else                                      state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (redirect_valid || room) state_d = S_FETCH;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        ce_n_d     = ce_n_q;
        oe_n_d     = oe_n_q;
        pending_d  = pending_q;
        target_d   = target_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_d       = redirect_aligned;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_d       = redirect_aligned;
                    oe_n_d     = 1'b0;
                end else if (!cache_hold) begin
                    if (room) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_next_seq;
                    end else begin
                        oe_n_d = 1'b1;
                    end
                end
            end
            S_MISS: begin
                // The cache is filling the line for pc_q, so the address must not move until hold drops.
                if (cache_hold) begin
                    if (redirect_valid) begin
                        fifo_flush = 1'b1;
                        pending_d  = 1'b1;
                        target_d   = redirect_aligned;
                    end
                end else if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_d       = redirect_aligned;
                    pending_d  = 1'b0;
                end else if (pending_q) begin
                    pc_d      = target_q;
                    pending_d = 1'b0;
                end else if (room) begin
                    fifo_push = 1'b1;
                    pc_d      = pc_next_seq;
                end else begin
                    oe_n_d = 1'b1;
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    fifo_flush = 1'b1;
                    pc_d       = redirect_aligned;
                    oe_n_d     = 1'b0;
                end else if (room) begin
                    oe_n_d = 1'b0;
                end
            end
            default: begin
                oe_n_d = 1'b1;
            end
        endcase
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .flush_i      (fifo_flush),
        .head_o       (head),
        .level_o      (fifo_level),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign cache_addr  = pc_q;
    assign cache_ce_n  = ce_n_q;
    assign cache_oe_n  = oe_n_q;
    assign instr_valid = !fifo_empty;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios, then random hold/ready/redirect traffic
// checked against an instruction-stream model (next expected pc, memory contents by address).
module tb_instr_fetch_unit;
    localparam logic [31:0] START = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] cache_addr;
    logic        cache_ce_n;
    logic        cache_oe_n;
    logic [31:0] cache_data;
    logic        cache_hold;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [2:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Cache model: real contents when not holding, recognisable garbage during a fill.
    assign cache_data = cache_hold ? (32'hDEAD_0000 | {16'h0, cache_addr[15:0]}) : mem_word(cache_addr);

    instr_fetch_unit #(
        .START_ADDRESS (START),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .cache_addr     (cache_addr),
        .cache_ce_n     (cache_ce_n),
        .cache_oe_n     (cache_oe_n),
        .cache_data     (cache_data),
        .cache_hold     (cache_hold),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fifo_level     (fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] pre_addr;
    logic [31:0] pre_ipc;
    logic        pre_hold;
    logic        pre_oe;
    logic        pre_stall;
    logic        prev_hold;
    int          miss_left;
    int          pops;

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cache_hold     = 1'b0;
        instr_ready    = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_addr",  cache_addr, START);
        chk("rst_ce_n",  cache_ce_n, 1'b1);
        chk("rst_oe_n",  cache_oe_n, 1'b1);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_data",  instr_data, 32'h0);
        chk("rst_pc",    instr_pc, 32'h0);
        chk("rst_level", fifo_level, 3'd0);
        tick;
        tick;
        reset_n = 1'b1;

        // Sequential hits, decode always ready
        tick;
        chk("boot_ce_n", cache_ce_n, 1'b0);
        chk("boot_oe_n", cache_oe_n, 1'b0);
        chk("boot_addr", cache_addr, START);
        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("seq_addr",  cache_addr, START + 32'(4 * k));
            chk("seq_pc",    instr_pc, START + 32'(4 * (k - 1)));
            chk("seq_data",  instr_data, mem_word(START + 32'(4 * (k - 1))));
            chk("seq_level", fifo_level, 3'd1);
        end

        // Five-cycle miss at 0x00400020
        cache_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("miss_addr", cache_addr, 32'h0040_0020);
            chk("miss_oe_n", cache_oe_n, 1'b0);
        end
        chk("miss_level", fifo_level, 3'd0);
        cache_hold = 1'b0;
        tick;
        chk("miss_next_addr", cache_addr, 32'h0040_0024);
        chk("miss_push_pc",   instr_pc, 32'h0040_0020);
        chk("miss_push_data", instr_data, mem_word(32'h0040_0020));
        chk("miss_one_push",  fifo_level, 3'd1);
        tick;
        chk("miss_after_pc",  instr_pc, 32'h0040_0024);

        // Backpressure fills the buffer
        reset_n = 1'b0;
        instr_ready = 1'b0;
        tick;
        reset_n = 1'b1;
        tick;
        repeat (4) tick;
        chk("full_level4", fifo_level, 3'd4);
        tick;
        chk("full_level", fifo_level, 3'd4);
        chk("full_oe_n",  cache_oe_n, 1'b1);
        chk("full_addr",  cache_addr, 32'h0040_0010);
        tick;
        chk("full_hold_pc",   instr_pc, START);
        chk("full_hold_data", instr_data, mem_word(START));
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        chk("unfull_level", fifo_level, 3'd3);
        chk("unfull_oe_n",  cache_oe_n, 1'b0);
        chk("unfull_addr",  cache_addr, 32'h0040_0010);
        chk("unfull_pc",    instr_pc, START + 32'h4);
        tick;
        chk("resume_level", fifo_level, 3'd4);
        chk("resume_addr",  cache_addr, 32'h0040_0014);

        // Redirect arriving in the middle of a miss
        reset_n = 1'b0;
        instr_ready = 1'b1;
        tick;
        reset_n = 1'b1;
        tick;
        repeat (16) tick;
        chk("pre_miss_addr", cache_addr, 32'h0040_0040);
        cache_hold = 1'b1;
        instr_ready = 1'b0;
        tick;
        chk("rmiss_level_before", fifo_level, 3'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0103;
        tick;
        redirect_valid = 1'b0;
        chk("rmiss_flush_level", fifo_level, 3'd0);
        chk("rmiss_flush_valid", instr_valid, 1'b0);
        chk("rmiss_addr_held",   cache_addr, 32'h0040_0040);
        chk("rmiss_oe_n",        cache_oe_n, 1'b0);
        tick;
        tick;
        chk("rmiss_addr_held2",  cache_addr, 32'h0040_0040);
        cache_hold = 1'b0;
        tick;
        chk("rmiss_target_addr", cache_addr, 32'h0040_0100);
        chk("rmiss_dropped",     fifo_level, 3'd0);
        instr_ready = 1'b1;
        tick;
        chk("rmiss_first_pc",    instr_pc, 32'h0040_0100);
        chk("rmiss_first_data",  instr_data, mem_word(32'h0040_0100));

        // Redirect on the same edge as a hit push and a decode pop
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0200;
        tick;
        redirect_valid = 1'b0;
        chk("rpop_level", fifo_level, 3'd0);
        chk("rpop_valid", instr_valid, 1'b0);
        chk("rpop_addr",  cache_addr, 32'h0040_0200);
        tick;
        chk("rpop_next_pc", instr_pc, 32'h0040_0200);
        chk("rpop_level1",  fifo_level, 3'd1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick;
        redirect_valid = 1'b0;
        chk("wrap_addr0", cache_addr, 32'hFFFF_FFF8);
        tick;
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        tick;
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_addr2", cache_addr, 32'h0000_0000);
        tick;
        chk("wrap_pc2", instr_pc, 32'h0000_0000);
        chk("wrap_data2", instr_data, mem_word(32'h0000_0000));
        chk("wrap_no_x", 32'($isunknown({cache_addr, cache_ce_n, cache_oe_n, instr_valid,
                                          instr_data, instr_pc, fifo_level})), 32'h0);

        // Asynchronous reset in the middle of a miss
        cache_hold = 1'b1;
        tick;
        tick;
        reset_n = 1'b0;
        #1;
        chk("amiss_addr",  cache_addr, START);
        chk("amiss_oe_n",  cache_oe_n, 1'b1);
        chk("amiss_ce_n",  cache_ce_n, 1'b1);
        chk("amiss_level", fifo_level, 3'd0);
        cache_hold = 1'b0;
        tick;
        reset_n = 1'b1;

        // Random traffic against the stream model
        exp_pc = START;
        miss_left = 0;
        pops = 0;
        prev_hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if (miss_left == 0 && cache_oe_n == 1'b0 && $urandom_range(0, 7) == 0)
                miss_left = $urandom_range(1, 5);
            cache_hold = (miss_left > 0);
            redirect_valid = 1'b0;
            if (!(cache_hold && !prev_hold) && $urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 1) == 1) redirect_pc = $urandom;
                else                           redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            #1;
            chk("rnd_valid_vs_level", instr_valid, 32'(fifo_level != 3'd0));
            chk("rnd_level_bound", 32'(fifo_level <= 3'd4), 32'h1);
            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (instr_valid && instr_ready) begin
                chk("rnd_pc",   instr_pc, exp_pc);
                chk("rnd_data", instr_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            pre_addr  = cache_addr;
            pre_ipc   = instr_pc;
            pre_hold  = cache_hold;
            pre_oe    = cache_oe_n;
            pre_stall = instr_valid && !instr_ready && !redirect_valid;
            prev_hold = cache_hold;
            tick;
            if (miss_left > 0) miss_left--;
            if (pre_hold && !pre_oe) begin
                chk("rnd_stall_addr", cache_addr, pre_addr);
                chk("rnd_stall_oe_n", cache_oe_n, 1'b0);
            end
            if (pre_stall) begin
                chk("rnd_hold_valid", instr_valid, 1'b1);
                chk("rnd_hold_pc",    instr_pc, pre_ipc);
            end
        end
        redirect_valid = 1'b0;
        cache_hold = 1'b0;
        chk("rnd_progress", 32'(pops > 300), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
